// File: rtl/idu_pkg.sv
// ============================================================================
// Module      : idu_pkg
// Description : Shared constants, opcodes, branch codes and decoder state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package idu_pkg;

    localparam logic [3:0] c_alu_add    = 4'b0000;
    localparam logic [3:0] c_alu_sub    = 4'b0001;
    localparam logic [3:0] c_alu_sll    = 4'b0010;
    localparam logic [3:0] c_alu_slt    = 4'b0100;
    localparam logic [3:0] c_alu_sltu   = 4'b0110;
    localparam logic [3:0] c_alu_xor    = 4'b1000;
    localparam logic [3:0] c_alu_srl    = 4'b1010;
    localparam logic [3:0] c_alu_sra    = 4'b1011;
    localparam logic [3:0] c_alu_or     = 4'b1100;
    localparam logic [3:0] c_alu_and    = 4'b1110;
    localparam logic [3:0] c_alu_pass_b = 4'b1111;

    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_system = 7'b1110011;

    localparam logic [6:0]  c_f7_alt      = 7'b0100000;
    localparam logic [31:0] c_inst_ebreak = 32'h00100073;

    localparam logic [2:0] c_br_beq  = 3'b000;
    localparam logic [2:0] c_br_bne  = 3'b001;
    localparam logic [2:0] c_br_blt  = 3'b100;
    localparam logic [2:0] c_br_bge  = 3'b101;
    localparam logic [2:0] c_br_bltu = 3'b110;
    localparam logic [2:0] c_br_bgeu = 3'b111;
    // funct3 010 is never a branch, so it doubles as "not a branch"
    localparam logic [2:0] c_br_none = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FULL = 2'd1,
        ST_HALT = 2'd2
    } idu_state_e;

    // The ALU code set is laid out as {funct3, alternate-encoding bit}
    function automatic logic [3:0] alu_code(input logic [2:0] funct3, input logic alt);
        return {funct3, alt};
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_gen.sv
// ============================================================================
// Module      : imm_gen
// Description : Combinational immediate extraction for all RV32I formats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen
    import idu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (inst[6:0])
            c_op_imm, c_op_load, c_op_jalr, c_op_system:
                imm = {{(XLEN-11){inst[31]}}, inst[30:20]};
            c_op_store:
                imm = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
            c_op_branch:
                imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            c_op_lui, c_op_auipc:
                imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
            c_op_jal:
                imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/idu_decode.sv
// ============================================================================
// Module      : idu_decode
// Description : RV32I decode stage with one-entry skid and HALT on ebreak/illegal.
//               Define IDU_RV32E_EN to reject register indices 16..31.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idu_decode
    import idu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_op,
    output logic            src_a_pc,
    output logic            src_b_imm,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            reg_wen,
    output logic            mem_ren,
    output logic            mem_wen,
    output logic [2:0]      mem_size,
    output logic [2:0]      br_type,
    output logic            jump,
    output logic [XLEN-1:0] out_pc,
    output logic            ebreak,
    output logic            illegal
);

`ifdef IDU_RV32E_EN
    localparam logic c_rv32e = 1'b1;
`else
    localparam logic c_rv32e = 1'b0;
`endif

    idu_state_e      r_state;
    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm;
    logic            w_legal, w_illegal, w_ebreak, w_capture;
    logic            w_use_rs1, w_use_rs2, w_use_rd;
    logic [3:0]      w_alu_op;
    logic            w_a_pc, w_b_imm, w_reg_wen, w_mem_ren, w_mem_wen, w_jump;
    logic [2:0]      w_br_type;

    assign w_opcode = inst[6:0];
    assign w_f3     = inst[14:12];
    assign w_f7     = inst[31:25];
    assign w_ebreak = (inst == c_inst_ebreak);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (inst),
        .imm  (w_imm)
    );

    always_comb begin
        w_legal   = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        w_alu_op  = c_alu_add;
        w_a_pc    = 1'b0;
        w_b_imm   = 1'b0;
        w_reg_wen = 1'b0;
        w_mem_ren = 1'b0;
        w_mem_wen = 1'b0;
        w_jump    = 1'b0;
        w_br_type = c_br_none;
        case (w_opcode)
            c_op_imm: begin
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_b_imm   = 1'b1;
                w_reg_wen = 1'b1;
                w_alu_op  = alu_code(w_f3, (w_f3 == 3'b101) && w_f7[5]);
                case (w_f3)
                    3'b001:  w_legal = (w_f7 == 7'b0);
                    3'b101:  w_legal = (w_f7 == 7'b0) || (w_f7 == c_f7_alt);
                    default: w_legal = 1'b1;
                endcase
            end
            c_op_reg: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_rd  = 1'b1;
                w_reg_wen = 1'b1;
                w_alu_op  = alu_code(w_f3, w_f7 == c_f7_alt);
                w_legal   = (w_f7 == 7'b0) ||
                            ((w_f7 == c_f7_alt) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
            end
            c_op_load: begin
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_b_imm   = 1'b1;
                w_reg_wen = 1'b1;
                w_mem_ren = 1'b1;
                w_legal   = (w_f3 != 3'b011) && (w_f3[2:1] != 2'b11);
            end
            c_op_store: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_b_imm   = 1'b1;
                w_mem_wen = 1'b1;
                w_legal   = !w_f3[2] && (w_f3[1:0] != 2'b11);
            end
            c_op_branch: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_br_type = w_f3;
                w_alu_op  = !w_f3[2] ? c_alu_sub : (w_f3[1] ? c_alu_sltu : c_alu_slt);
                w_legal   = (w_f3[2:1] != 2'b01);
            end
            c_op_jal: begin
                w_use_rd  = 1'b1;
                w_a_pc    = 1'b1;
                w_b_imm   = 1'b1;
                w_reg_wen = 1'b1;
                w_jump    = 1'b1;
                w_legal   = 1'b1;
            end
            c_op_jalr: begin
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_b_imm   = 1'b1;
                w_reg_wen = 1'b1;
                w_jump    = 1'b1;
                w_legal   = (w_f3 == 3'b000);
            end
            c_op_lui: begin
                w_use_rd  = 1'b1;
                w_alu_op  = c_alu_pass_b;
                w_b_imm   = 1'b1;
                w_reg_wen = 1'b1;
                w_legal   = 1'b1;
            end
            c_op_auipc: begin
                w_use_rd  = 1'b1;
                w_a_pc    = 1'b1;
                w_b_imm   = 1'b1;
                w_reg_wen = 1'b1;
                w_legal   = 1'b1;
            end
            c_op_system: w_legal = w_ebreak;
            default:     w_legal = 1'b0;
        endcase

        w_illegal = !w_legal ||
                    (c_rv32e && |({w_use_rs1, w_use_rs2, w_use_rd} & {inst[19], inst[24], inst[11]}));

        // Illegal words must never cause side effects downstream
        if (w_illegal) begin
            w_alu_op  = c_alu_add;
            w_a_pc    = 1'b0;
            w_b_imm   = 1'b0;
            w_reg_wen = 1'b0;
            w_mem_ren = 1'b0;
            w_mem_wen = 1'b0;
            w_jump    = 1'b0;
            w_br_type = c_br_none;
        end
    end

    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_FULL) && out_ready);
    assign out_valid = (r_state != ST_IDLE);
    assign w_capture = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            alu_op    <= '0;
            src_a_pc  <= 1'b0;
            src_b_imm <= 1'b0;
            imm       <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            reg_wen   <= 1'b0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_size  <= '0;
            br_type   <= '0;
            jump      <= 1'b0;
            out_pc    <= '0;
            ebreak    <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else if (w_capture) begin
            r_state   <= (w_ebreak || w_illegal) ? ST_HALT : ST_FULL;
            alu_op    <= w_alu_op;
            src_a_pc  <= w_a_pc;
            src_b_imm <= w_b_imm;
            imm       <= w_imm;
            rs1       <= inst[19:15];
            rs2       <= inst[24:20];
            rd        <= inst[11:7];
            reg_wen   <= w_reg_wen;
            mem_ren   <= w_mem_ren;
            mem_wen   <= w_mem_wen;
            mem_size  <= w_f3;
            br_type   <= w_br_type;
            jump      <= w_jump;
            out_pc    <= pc;
            ebreak    <= w_ebreak;
            illegal   <= w_illegal;
        end else if ((r_state == ST_FULL) && out_ready) begin
            r_state <= ST_IDLE;
        end
    end

endmodule

`default_nettype wire

// File: doc/idu_decode.md
IDU_DECODE -- requirements
Module: idu_decode

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports in_valid (input, 1), in_ready (output, 1), inst (input, 32), pc (input, XLEN): fetch-side handshake, instruction word and its address.
REQ-005 SHALL have port flush, input, 1, which kills the held entry and leaves HALT.
REQ-006 SHALL have ports out_valid (output, 1) and out_ready (input, 1): execute-side handshake.
REQ-007 SHALL have registered outputs alu_op (4), src_a_pc (1: A=pc, else rs1), src_b_imm (1: B=imm, else rs2), imm (XLEN), rs1/rs2/rd (5 each), reg_wen, mem_ren, mem_wen (1 each), mem_size (3: funct3), br_type (3), jump (1), out_pc (XLEN), ebreak (1), illegal (1).

Function
REQ-008 SHALL use this alu_op code set: ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110, PASS_B 1111.
REQ-009 SHALL decode OP/OP-IMM by funct3/funct7 to those codes; SUB only for OP with funct7=0100000; SRAI/SRA for funct7=0100000, SRLI/SRL/SLLI otherwise.
REQ-010 SHALL decode LOAD/STORE/JAL/JALR/AUIPC as ADD, AUIPC/JAL with src_a_pc=1; LUI as PASS_B with src_b_imm=1.
REQ-011 SHALL decode BEQ/BNE as SUB, BLT/BGE as SLT, BLTU/BGEU as SLTU, src_b_imm=0, br_type=funct3, reg_wen=0.
REQ-012 SHALL sign-extend I/S/B/J immediates and zero-fill U[11:0]; B and J bit 0 is 0.
REQ-013 SHALL flag illegal=1, with reg_wen=mem_ren=mem_wen=jump=0, for any unrecognised opcode/funct3/funct7.
REQ-014 SHALL implement states IDLE (empty), FULL (entry held), HALT (entry held, intake blocked).
REQ-015 SHALL drive in_ready = (state==IDLE) | (state==FULL & out_ready) and not from flush; out_valid = (state!=IDLE) combinationally from state only.
REQ-016 SHALL capture when in_valid&in_ready: next state HALT if decoded ebreak or illegal, else FULL.
REQ-017 SHALL go FULL->IDLE on out_ready with no capture; in HALT SHALL keep out_valid=1 and ignore out_ready until flush.
REQ-018 SHALL on flush go to IDLE next cycle from any state, discarding a same-cycle capture (flush wins).
REQ-019 SHALL hold all output registers stable while out_valid=1 and out_ready=0.
REQ-020 SHALL have exactly one cycle latency from capture to out_valid.

Reset
REQ-021 SHALL on rst_n=0 immediately enter IDLE, clear out_valid and every output register to 0, and drive in_ready=1 after release.
REQ-022 SHALL abandon any in-flight entry on reset mid-operation; no output is produced for it.

Configuration
REQ-023 SHALL, with IDU_RV32E_EN defined, flag illegal when any used rs1/rs2/rd index has bit 4 set; without it, all 32 indices are legal.

Structure
REQ-024 SHALL place alu_op code constants, opcode constants, br_type codes and the state typedef in a shared package idu_pkg, also imported by the ALU.
REQ-025 SHALL use sub-module imm_gen (inst -> imm, combinational); decode logic and state machine stay in idu_decode.

Verification
REQ-026 SHALL check: 0x00500093 (addi x1,x0,5) -> next cycle out_valid=1, alu_op=0000, src_b_imm=1, imm=5, rd=1, reg_wen=1.
REQ-027 SHALL check: 0x402081B3 (sub x3,x1,x2) -> alu_op=0001, src_b_imm=0; 0x40335293 (srai x5,x6,3) -> alu_op=1011, imm[4:0]=3.
REQ-028 SHALL check: 0xFE20EEE3 (bltu x1,x2,-4) -> alu_op=0110, imm=0xFFFFFFFC, br_type=110, reg_wen=0.
REQ-029 SHALL check: out_ready=0 for 3 cycles while FULL with in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> new word captured same cycle.
REQ-030 SHALL check: 0x00100073 -> ebreak=1, HALT, in_ready=0 despite out_ready=1; flush -> IDLE and in_ready=1 next cycle.
REQ-031 SHALL check: 0x00000833 (add x16,x0,x0) -> illegal=1 with IDU_RV32E_EN, illegal=0 and rd=16 without.
